// File: rtl/adc_rx_sequencer.sv
// adc_rx_sequencer: scan controller for the serial ADC receive path.
// A divider paces scans. Each scan walks the latched channel mask from the
// lowest set bit upwards. For each channel it frames one SPI transfer: the
// address goes out on MOSI MSB first and the result comes in on MISO, first
// sampled bit in the LSB. Results go to a single-entry valid/ready buffer.
// All outputs are registered copies of the next-state decode.
module adc_rx_sequencer #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_CH     = 4,
    parameter int FRAME_BITS = 16,
    parameter int HOLD_CYC   = 4,
    parameter int TRIG_DIV   = 100
) (
    input  logic                 spi_clk_rx,
    input  logic                 RST_n,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 clr_err,
    input  logic                 spi_miso,
    output logic                 spi_cs_n,
    output logic                 spi_mosi,
    output logic                 sclk_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [ADDR_BITS-1:0] rx_ch,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 trig_miss
);

    localparam int CNT_MAX      = (FRAME_BITS > HOLD_CYC) ? FRAME_BITS : HOLD_CYC;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);
    localparam int DIV_W        = $clog2(TRIG_DIV);
    localparam int SAMPLE_START = FRAME_BITS - DATA_BITS;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TRIG = 3'd1,
        S_SETUP     = 3'd2,
        S_SHIFT     = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    // Lowest set bit of mask at or above start; MSB of the result flags "found".
    function automatic logic [ADDR_BITS:0] find_ch(input logic [NUM_CH-1:0] mask,
                                                   input int start);
        logic [ADDR_BITS:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                r = {1'b1, ADDR_BITS'(i)};
            end
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [ADDR_BITS-1:0] ch_q, ch_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 cs_n_q, cs_n_d;
    logic                 mosi_q, mosi_d;
    logic                 sclk_en_q, sclk_en_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic [ADDR_BITS-1:0] rx_ch_q, rx_ch_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 trig_miss_q, trig_miss_d;

    logic                 trig_s;
    logic                 frame_done_s;
    logic                 hold_done_s;
    logic                 ovr_set_s;
    logic                 miss_set_s;
    logic [ADDR_BITS:0]   first_s;
    logic [ADDR_BITS:0]   next_s;
    logic [ADDR_BITS-1:0] addr_sh_s;

    assign trig_s       = (div_q == DIV_W'(TRIG_DIV - 1));
    assign frame_done_s = (state_q == S_SHIFT) && (cnt_q == CNT_W'(FRAME_BITS - 1));
    assign hold_done_s  = (state_q == S_HOLD) && (cnt_q == CNT_W'(HOLD_CYC - 1));
    assign first_s      = find_ch(ch_mask, 0);
    assign next_s       = find_ch(mask_q, int'(ch_q) + 1);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_ch_d    = rx_ch_q;
        rx_valid_d = rx_valid_q;
        ovr_set_s  = 1'b0;

        if (enable) begin
            if (trig_s) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT_TRIG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_TRIG: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (trig_s && (ch_mask != '0)) begin
                    mask_d  = ch_mask;
                    ch_d    = first_s[ADDR_BITS-1:0];
                    state_d = S_SETUP;
                end else begin
                    state_d = S_WAIT_TRIG;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q >= CNT_W'(SAMPLE_START)) begin
                    shreg_d = {spi_miso, shreg_q[DATA_BITS-1:1]};
                end else begin
                    shreg_d = shreg_q;
                end
                if (frame_done_s) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_done_s) begin
                    cnt_d = '0;
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (next_s[ADDR_BITS]) begin
                        ch_d    = next_s[ADDR_BITS-1:0];
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_WAIT_TRIG;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A finished frame is offered to the buffer; a full, stalled buffer drops it.
        if (frame_done_s) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_d;
                rx_ch_d    = ch_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        miss_set_s  = trig_s && (state_q != S_WAIT_TRIG);
        overrun_d   = ovr_set_s  | (overrun_q   & ~clr_err);
        trig_miss_d = miss_set_s | (trig_miss_q & ~clr_err);

        addr_sh_s = ch_d << cnt_d;
        cs_n_d    = !((state_d == S_SETUP) || (state_d == S_SHIFT));
        sclk_en_d = (state_d == S_SHIFT);
        busy_d    = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        mosi_d    = ((state_d == S_SHIFT) && (cnt_d < CNT_W'(ADDR_BITS)))
                    ? addr_sh_s[ADDR_BITS-1] : 1'b0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge spi_clk_rx) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            ch_q        <= '0;
            shreg_q     <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            sclk_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_ch_q     <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            trig_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            shreg_q     <= shreg_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            sclk_en_q   <= sclk_en_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_ch_q     <= rx_ch_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            trig_miss_q <= trig_miss_d;
        end
    end

    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;
    assign sclk_en   = sclk_en_q;
    assign busy      = busy_q;
    assign rx_data   = rx_data_q;
    assign rx_ch     = rx_ch_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign trig_miss = trig_miss_q;

endmodule

// File: tb/tb_adc_rx_sequencer.sv
// Testbench for adc_rx_sequencer: an ADC model answers each frame with the
// data of the addressed channel, a scoreboard holds expected results and
// expected MOSI addresses, and a table of scan vectors drives the main run.
`timescale 1ns/1ps
module tb_adc_rx_sequencer;

    localparam int DB = 8;
    localparam int AB = 2;
    localparam int NC = 4;
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, clr_err, miso, rx_ready;
    logic [NC-1:0] ch_mask;
    logic          cs_n, mosi, sclk_en, rx_valid, busy, overrun, trig_miss;
    logic [DB-1:0] rx_data;
    logic [AB-1:0] rx_ch;

    logic          enable_f, clr_err_f, rx_ready_f;
    logic [NC-1:0] ch_mask_f;
    logic          cs_n_f, mosi_f, sclk_en_f, rx_valid_f, busy_f, overrun_f, trig_miss_f;
    logic [DB-1:0] rx_data_f;
    logic [AB-1:0] rx_ch_f;

    always #5 clk = ~clk;

    adc_rx_sequencer dut (
        .spi_clk_rx(clk), .RST_n(rst_n), .enable(enable), .ch_mask(ch_mask),
        .clr_err(clr_err), .spi_miso(miso), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .sclk_en(sclk_en), .rx_data(rx_data), .rx_ch(rx_ch), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy), .overrun(overrun), .trig_miss(trig_miss)
    );

    adc_rx_sequencer #(.TRIG_DIV(20)) dut_f (
        .spi_clk_rx(clk), .RST_n(rst_n), .enable(enable_f), .ch_mask(ch_mask_f),
        .clr_err(clr_err_f), .spi_miso(1'b0), .spi_cs_n(cs_n_f), .spi_mosi(mosi_f),
        .sclk_en(sclk_en_f), .rx_data(rx_data_f), .rx_ch(rx_ch_f), .rx_valid(rx_valid_f),
        .rx_ready(rx_ready_f), .busy(busy_f), .overrun(overrun_f), .trig_miss(trig_miss_f)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [AB-1:0] ch;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [AB-1:0] exp_addr_q[$];
    logic [DB-1:0] ch_data [NC];
    int            frames     = 0;
    int            last_gap   = 0;
    int            hi_run     = 0;
    int            fast_cnt   = 0;
    logic          seen_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data(input logic [DB-1:0] seed);
        for (int c = 0; c < NC; c++) begin
            ch_data[c] = seed + DB'(c * 41);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},      32'(cs_n),      32'(1));
        check({tag, "_mosi"},      32'(mosi),      32'(0));
        check({tag, "_sclk_en"},   32'(sclk_en),   32'(0));
        check({tag, "_rx_data"},   32'(rx_data),   32'(0));
        check({tag, "_rx_ch"},     32'(rx_ch),     32'(0));
        check({tag, "_rx_valid"},  32'(rx_valid),  32'(0));
        check({tag, "_busy"},      32'(busy),      32'(0));
        check({tag, "_overrun"},   32'(overrun),   32'(0));
        check({tag, "_trig_miss"}, 32'(trig_miss), 32'(0));
    endtask

    task automatic wait_shift(input string tag);
        int w;
        w = 0;
        while (!sclk_en && w < 150) begin
            tick();
            w++;
        end
        if (!sclk_en) flag_fail({tag, "_shift_timeout"});
    endtask

    // ADC model: decodes the MOSI address, returns that channel's data LSB first.
    initial begin : adc_model
        int            k;
        logic [AB-1:0] addr_cap;
        logic [AB-1:0] ea;
        k        = 0;
        addr_cap = '0;
        miso     = 1'b0;
        forever begin
            @(negedge clk);
            if (cs_n) begin
                hi_run++;
            end else begin
                if (hi_run > 0) last_gap = hi_run;
                hi_run = 0;
            end
            if (sclk_en) begin
                if (k < AB) addr_cap = {addr_cap[AB-2:0], mosi};
                if (k >= FB - DB) miso = ch_data[addr_cap][k-(FB-DB)];
                if (k == FB - 1) begin
                    frames++;
                    if (exp_addr_q.size() == 0) begin
                        flag_fail("unexpected_frame");
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("mosi_addr", 32'(addr_cap), 32'(ea));
                    end
                end
                k++;
            end else begin
                k    = 0;
                miso = 1'b0;
            end
        end
    end

    // Result monitor: each valid&ready cycle is one accepted result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid) seen_valid = 1'b1;
            if (rst_n && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("rx_ch",   32'(rx_ch),   32'(e.ch));
                    check("rx_data", 32'(rx_data), 32'(e.data));
                end
            end
            if (rst_n && rx_valid_f && rx_ready_f) begin
                check("fast_rx_ch",   32'(rx_ch_f),   32'(fast_cnt % NC));
                check("fast_rx_data", 32'(rx_data_f), 32'(0));
                fast_cnt++;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NC-1:0] mask;
        logic [DB-1:0] seed;
        int            exp_frames;
        logic [AB-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int f0, first_cs, first_valid;

        vecs[0] = '{mask: 4'b0001, seed: 8'h0D, exp_frames: 1, exp_last: 2'd0};
        vecs[1] = '{mask: 4'b1010, seed: 8'h5A, exp_frames: 2, exp_last: 2'd3};
        vecs[2] = '{mask: 4'b1111, seed: 8'hC3, exp_frames: 4, exp_last: 2'd3};
        vecs[3] = '{mask: 4'b0110, seed: 8'h77, exp_frames: 2, exp_last: 2'd2};
        vecs[4] = '{mask: 4'b1000, seed: 8'hE1, exp_frames: 1, exp_last: 2'd3};
        vecs[5] = '{mask: 4'b0000, seed: 8'h11, exp_frames: 0, exp_last: 2'd0};

        rst_n      = 1'b0;
        enable     = 1'b0;
        ch_mask    = '0;
        clr_err    = 1'b0;
        rx_ready   = 1'b1;
        enable_f   = 1'b0;
        ch_mask_f  = 4'b1111;
        clr_err_f  = 1'b0;
        rx_ready_f = 1'b1;
        load_data(8'h00);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("init");

        // Table-driven scans with rx_ready held high.
        for (int v = 0; v < 6; v++) begin
            load_data(vecs[v].seed);
            for (int c = 0; c < NC; c++) begin
                if (vecs[v].mask[c]) begin
                    exp_addr_q.push_back(AB'(c));
                    exp_q.push_back({AB'(c), ch_data[c]});
                end
            end
            f0          = frames;
            first_cs    = -1;
            first_valid = -1;
            ch_mask     = vecs[v].mask;
            enable      = 1'b1;
            for (int c = 1; c <= 192; c++) begin
                tick();
                if (first_cs < 0 && !cs_n) first_cs = c;
                if (first_valid < 0 && rx_valid) first_valid = c;
            end
            enable = 1'b0;
            repeat (3) tick();
            check("frame_count", 32'(frames - f0), 32'(vecs[v].exp_frames));
            check("busy_after",  32'(busy),        32'(0));
            check("trig_miss",   32'(trig_miss),   32'(0));
            check("overrun",     32'(overrun),     32'(0));
            if (vecs[v].exp_frames > 0) begin
                check("cs_n_latency",  32'(first_cs),    32'(100));
                check("valid_latency", 32'(first_valid), 32'(117));
                check("last_rx_ch",    32'(rx_ch),       32'(vecs[v].exp_last));
            end
            if (vecs[v].exp_frames > 1) check("cs_gap", 32'(last_gap), 32'(4));
            if (v == 0) check("rx_data_0D", 32'(rx_data), 32'(8'h0D));
        end

        // Stalled downstream: the second result is dropped and overrun sets.
        load_data(8'h96);
        exp_addr_q.push_back(2'd0);
        exp_addr_q.push_back(2'd1);
        exp_q.push_back({2'd0, ch_data[0]});
        rx_ready = 1'b0;
        ch_mask  = 4'b0011;
        enable   = 1'b1;
        repeat (192) tick();
        enable = 1'b0;
        repeat (3) tick();
        check("ovr_overrun",  32'(overrun),  32'(1));
        check("ovr_rx_valid", 32'(rx_valid), 32'(1));
        check("ovr_rx_ch",    32'(rx_ch),    32'(0));
        check("ovr_rx_data",  32'(rx_data),  32'(ch_data[0]));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_cleared",    32'(overrun),  32'(0));
        check("ovr_valid_kept", 32'(rx_valid), 32'(1));
        rx_ready = 1'b1;
        tick();
        check("ovr_valid_drained", 32'(rx_valid), 32'(0));

        // enable dropped during the ch0 shift of a two-channel scan.
        load_data(8'h3B);
        exp_addr_q.push_back(2'd0);
        exp_q.push_back({2'd0, ch_data[0]});
        ch_mask = 4'b0011;
        enable  = 1'b1;
        wait_shift("drop");
        seen_valid = 1'b0;
        f0         = frames;
        enable     = 1'b0;
        repeat (150) tick();
        check("drop_frames",     32'(frames - f0), 32'(1));
        check("drop_seen_valid", 32'(seen_valid),  32'(1));
        check("drop_busy",       32'(busy),        32'(0));
        check("drop_cs_n",       32'(cs_n),        32'(1));
        check("drop_rx_ch",      32'(rx_ch),       32'(0));

        // Fast divider: triggers land mid-scan but the scan runs through.
        enable_f = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (c == 45) begin
                check("fast_busy_mid", 32'(busy_f),      32'(1));
                check("fast_miss_mid", 32'(trig_miss_f), 32'(1));
            end
        end
        enable_f = 1'b0;
        repeat (3) tick();
        check("fast_results", 32'(fast_cnt),    32'(4));
        check("fast_miss",    32'(trig_miss_f), 32'(1));
        clr_err_f = 1'b1;
        tick();
        clr_err_f = 1'b0;
        check("fast_miss_clr", 32'(trig_miss_f), 32'(0));

        // Reset in the middle of a frame.
        load_data(8'h55);
        ch_mask = 4'b0001;
        enable  = 1'b1;
        wait_shift("midrst");
        repeat (3) tick();
        check("midrst_cs_low", 32'(cs_n), 32'(0));
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (3) tick();

        check("sb_results_left", 32'(exp_q.size()),      32'(0));
        check("sb_addrs_left",   32'(exp_addr_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
